// File: rtl/axi4_lite_master_ext_if.sv
// AXI4-Lite channel bundle for axi4_lite_master_ext (AW, W, B, AR, R).
interface axi4_lite_master_ext_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic                  BVALID;
  logic [1:0]            BRESP;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWCACHE, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARCACHE, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWCACHE, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARCACHE, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_master_ext.sv
// axi4_lite_master_ext: bridges the local BUS_* request/ack bus onto one AXI4-Lite master port.
// Define AXI4L_MASTER_TIMEOUT_EN to enable the response timeout and stale-response draining.
module axi4_lite_master_ext #(
  parameter int unsigned  ADDR_WIDTH     = 32,
  parameter int unsigned  DATA_WIDTH     = 32,
  parameter logic [3:0]   CACHE_VAL      = 4'b0011,
  parameter logic [2:0]   PROT_VAL       = 3'b000,
  parameter int unsigned  TIMEOUT_CYCLES = 1024,
  localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi4_lite_master_ext_if.master axi,
  input  logic                   BUS_ENA,
  input  logic [STRB_WIDTH-1:0]  BUS_WSTB,
  input  logic [ADDR_WIDTH-1:0]  BUS_ADDR,
  input  logic [DATA_WIDTH-1:0]  BUS_WDATA,
  output logic                   BUS_WAIT,
  output logic                   BUS_ACK,
  output logic [DATA_WIDTH-1:0]  BUS_RDATA,
  output logic [1:0]             BUS_RESP,
  output logic                   BUS_ERR
);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || ADDR_WIDTH < 12 || ADDR_WIDTH > 64 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi4_lite_master_ext: unsupported parameter value");
  end

  typedef enum logic [2:0] {
    StIdle, StWrAddrData, StWrResp, StRdAddr, StRdData, StDone
  } state_e;

  state_e                state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  stale_b_q, stale_r_q;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXI4L_MASTER_TIMEOUT_EN
  localparam int unsigned      CntW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0]  CntMax = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stale_b_d, stale_r_d;
`else
  assign stale_b_q = 1'b0;
  assign stale_r_q = 1'b0;
`endif

  assign aw_hs = axi.AWVALID & axi.AWREADY;
  assign w_hs  = axi.WVALID & axi.WREADY;
  assign b_hs  = axi.BVALID & axi.BREADY;
  assign ar_hs = axi.ARVALID & axi.ARREADY;
  assign r_hs  = axi.RVALID & axi.RREADY;

  // Next-state, capture and response bookkeeping.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    err_d     = err_q;
`ifdef AXI4L_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
    // A response arriving while a channel is stale belongs to the abandoned transaction.
    stale_b_d = stale_b_q & ~b_hs;
    stale_r_d = stale_r_q & ~r_hs;
`endif
    unique case (state_q)
      StIdle: begin
        if (BUS_ENA) begin
          addr_d    = BUS_ADDR;
          wdata_d   = BUS_WDATA;
          wstrb_d   = BUS_WSTB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXI4L_MASTER_TIMEOUT_EN
          cnt_d     = '0;
`endif
          state_d   = (|BUS_WSTB) ? StWrAddrData : StRdAddr;
        end
      end
      StWrAddrData: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = StWrResp;
      end
      StWrResp: begin
        if (b_hs && !stale_b_q) begin
          resp_d  = axi.BRESP;
          err_d   = axi.BRESP[1];
          state_d = StDone;
        end
`ifdef AXI4L_MASTER_TIMEOUT_EN
        else if (b_hs) cnt_d = '0;
        else if (cnt_q == CntMax) begin
          resp_d    = 2'b10;
          err_d     = 1'b1;
          stale_b_d = 1'b1;
          cnt_d     = '0;
          state_d   = StDone;
        end else cnt_d = cnt_q + CntW'(1);
`endif
      end
      StRdAddr: begin
        if (ar_hs) state_d = StRdData;
      end
      StRdData: begin
        if (r_hs && !stale_r_q) begin
          rdata_d = axi.RDATA;
          resp_d  = axi.RRESP;
          err_d   = axi.RRESP[1];
          state_d = StDone;
        end
`ifdef AXI4L_MASTER_TIMEOUT_EN
        else if (r_hs) cnt_d = '0;
        else if (cnt_q == CntMax) begin
          resp_d    = 2'b10;
          err_d     = 1'b1;
          stale_r_d = 1'b1;
          cnt_d     = '0;
          state_d   = StDone;
        end else cnt_d = cnt_q + CntW'(1);
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers, synchronous active-high reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      err_q     <= 1'b0;
`ifdef AXI4L_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
      stale_b_q <= 1'b0;
      stale_r_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
`ifdef AXI4L_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      stale_b_q <= stale_b_d;
      stale_r_q <= stale_r_d;
`endif
    end
  end

  assign axi.AWADDR  = addr_q;
  assign axi.AWCACHE = CACHE_VAL;
  assign axi.AWPROT  = PROT_VAL;
  assign axi.AWVALID = (state_q == StWrAddrData) && !aw_done_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WVALID  = (state_q == StWrAddrData) && !w_done_q;
  assign axi.BREADY  = (state_q == StWrResp) || stale_b_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARCACHE = CACHE_VAL;
  assign axi.ARPROT  = PROT_VAL;
  assign axi.ARVALID = (state_q == StRdAddr);
  assign axi.RREADY  = (state_q == StRdData) || stale_r_q;

  assign BUS_WAIT  = (state_q != StIdle) && (state_q != StDone);
  assign BUS_ACK   = (state_q == StDone);
  assign BUS_RDATA = rdata_q;
  assign BUS_RESP  = resp_q;
  assign BUS_ERR   = err_q;

endmodule

// File: tb/tb_axi4_lite_master_ext.sv
// Self-checking bench for axi4_lite_master_ext: vector table driven through a scripted AXI slave,
// with a scoreboard of expected completions checked whenever BUS_ACK pulses.
module tb_axi4_lite_master_ext;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
`ifdef AXI4L_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_ena;
  logic [SW-1:0] bus_wstb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_wait;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic [1:0]    bus_resp;
  logic          bus_err;

  axi4_lite_master_ext_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4_lite_master_ext #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK     (clk),
    .ARESET   (rst),
    .axi      (axi),
    .BUS_ENA  (bus_ena),
    .BUS_WSTB (bus_wstb),
    .BUS_ADDR (bus_addr),
    .BUS_WDATA(bus_wdata),
    .BUS_WAIT (bus_wait),
    .BUS_ACK  (bus_ack),
    .BUS_RDATA(bus_rdata),
    .BUS_RESP (bus_resp),
    .BUS_ERR  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            d_a;      // AWREADY / ARREADY delay
    int            d_w;      // WREADY delay
    int            d_resp;   // BVALID / RVALID delay once READY is up
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    logic [1:0]    exp_resp;
    logic          exp_err;
    int            exp_lat;  // accept cycle to BUS_ACK cycle
  } vec_t;

  typedef struct {
    logic [1:0]    resp;
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  vec_t          vecs[8];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            n_ack = 0;
  int            cyc = 0;
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Completion monitor: every BUS_ACK pops one expected result.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus_ack === 1'b1) begin
      n_ack++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got BUS_ACK at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_resp", bus_resp, e.resp);
        chk("ack_err", bus_err, e.err);
        chk("ack_rdata", bus_rdata, e.rdata);
        chk("ack_wait_low", bus_wait, 1'b0);
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic aw_chan(input int dly, input logic [AW-1:0] addr);
    int n = 0;
    while (axi.AWVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin bound_fail("awvalid_wait"); return; end
    chk("aw_bus_wait", bus_wait, 1'b1);
    repeat (dly) begin
      @(negedge clk);
      chk("awvalid_held", axi.AWVALID, 1'b1);
    end
    chk("awaddr", axi.AWADDR, addr);
    chk("awcache_prot", {axi.AWCACHE, axi.AWPROT}, 7'b0011_000);
    axi.AWREADY = 1'b1;
    @(negedge clk);
    axi.AWREADY = 1'b0;
    chk("awvalid_drop", axi.AWVALID, 1'b0);
  endtask

  task automatic w_chan(input int dly, input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int n = 0;
    while (axi.WVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin bound_fail("wvalid_wait"); return; end
    repeat (dly) begin
      @(negedge clk);
      chk("wvalid_held", axi.WVALID, 1'b1);
    end
    chk("wdata", axi.WDATA, data);
    chk("wstrb", axi.WSTRB, strb);
    axi.WREADY = 1'b1;
    @(negedge clk);
    axi.WREADY = 1'b0;
    chk("wvalid_drop", axi.WVALID, 1'b0);
  endtask

  task automatic b_chan(input int dly, input logic [1:0] resp);
    int n = 0;
    while (axi.BREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin bound_fail("bready_wait"); return; end
    repeat (dly) @(negedge clk);
    chk("bready_held", axi.BREADY, 1'b1);
    axi.BVALID = 1'b1;
    axi.BRESP  = resp;
    @(negedge clk);
    axi.BVALID = 1'b0;
    axi.BRESP  = 2'b00;
    chk("bready_drop", axi.BREADY, 1'b0);
  endtask

  task automatic ar_chan(input int dly, input logic [AW-1:0] addr);
    int n = 0;
    while (axi.ARVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin bound_fail("arvalid_wait"); return; end
    repeat (dly) begin
      @(negedge clk);
      chk("arvalid_held", axi.ARVALID, 1'b1);
    end
    chk("araddr", axi.ARADDR, addr);
    chk("arcache_prot", {axi.ARCACHE, axi.ARPROT}, 7'b0011_000);
    axi.ARREADY = 1'b1;
    @(negedge clk);
    axi.ARREADY = 1'b0;
    chk("arvalid_drop", axi.ARVALID, 1'b0);
  endtask

  task automatic r_chan(input int dly, input logic [1:0] resp, input logic [DW-1:0] data);
    int n = 0;
    while (axi.RREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin bound_fail("rready_wait"); return; end
    repeat (dly) @(negedge clk);
    chk("rready_held", axi.RREADY, 1'b1);
    axi.RVALID = 1'b1;
    axi.RDATA  = data;
    axi.RRESP  = resp;
    @(negedge clk);
    axi.RVALID = 1'b0;
    axi.RDATA  = '0;
    axi.RRESP  = 2'b00;
    chk("rready_drop", axi.RREADY, 1'b0);
  endtask

  task automatic wait_ack(input int start);
    for (int i = 0; i < 200 && n_ack == start; i++) @(posedge clk);
    if (n_ack == start) bound_fail("ack_wait");
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   start;
    start = n_ack;
    @(negedge clk);
    bus_ena   = 1'b1;
    bus_wstb  = v.wr ? v.strb : '0;
    bus_addr  = v.addr;
    bus_wdata = v.wdata;
    if (!v.wr && v.exp_lat >= 0 && !(v.exp_err && v.exp_resp == 2'b10 && v.d_resp < 0))
      model_rdata = v.rdata;
    e.resp  = v.exp_resp;
    e.err   = v.exp_err;
    e.rdata = model_rdata;
    e.cyc   = cyc + v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    bus_ena   = 1'b0;
    bus_wstb  = '0;
    bus_addr  = ~v.addr;
    bus_wdata = ~v.wdata;
    if (v.wr) begin
      chk("wr_valids_t1", {axi.AWVALID, axi.WVALID}, 2'b11);
      fork
        aw_chan(v.d_a, v.addr);
        w_chan(v.d_w, v.wdata, v.strb);
        b_chan(v.d_resp, v.resp);
      join
    end else begin
      chk("arvalid_t1", axi.ARVALID, 1'b1);
      fork
        ar_chan(v.d_a, v.addr);
        if (v.d_resp >= 0) r_chan(v.d_resp, v.resp, v.rdata);
      join
    end
    wait_ack(start);
    repeat (2) @(negedge clk);
    chk("rdata_held", bus_rdata, model_rdata);
  endtask

  initial begin
    int start;
    rst = 1'b1;
    bus_ena = 1'b0; bus_wstb = '0; bus_addr = '0; bus_wdata = '0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00;

    // wr, addr, wdata, strb, d_a, d_w, d_resp, resp, rdata, exp_resp, exp_err, exp_lat
    vecs[0] = '{1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0,        2'b00, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h200, 32'h0,        4'h0, 5, 0, 0, 2'b00, 32'h12345678, 2'b00, 1'b0, 8};
    vecs[2] = '{1'b1, 32'h104, 32'hCAFEF00D, 4'h3, 3, 0, 1, 2'b00, 32'h0,        2'b00, 1'b0, 7};
    vecs[3] = '{1'b0, 32'h300, 32'h0,        4'h0, 0, 0, 0, 2'b11, 32'h0BADF00D, 2'b11, 1'b1, 3};
    vecs[4] = '{1'b1, 32'h108, 32'h01234567, 4'hC, 0, 2, 0, 2'b10, 32'h0,        2'b10, 1'b1, 5};
    vecs[5] = '{1'b0, 32'h204, 32'h0,        4'h0, 1, 0, 2, 2'b01, 32'h600DCAFE, 2'b01, 1'b0, 6};
    vecs[6] = '{1'b1, 32'hFFC, 32'h89ABCDEF, 4'h8, 1, 1, 3, 2'b11, 32'h0,        2'b11, 1'b1, 7};
    vecs[7] = '{1'b0, 32'h400, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hA5A55A5A, 2'b00, 1'b0, 3};

    repeat (3) @(negedge clk);
    chk("rst_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID}, 3'b000);
    chk("rst_readys", {axi.BREADY, axi.RREADY}, 2'b00);
    chk("rst_bus", {bus_wait, bus_ack, bus_resp, bus_err}, 5'b0);
    chk("rst_rdata", bus_rdata, '0);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset while waiting for the write response: abort with no completion pulse.
    start = n_ack;
    @(negedge clk);
    bus_ena = 1'b1; bus_wstb = 4'hF; bus_addr = 32'h700; bus_wdata = 32'h77;
    @(negedge clk);
    bus_ena = 1'b0; bus_wstb = '0;
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    @(negedge clk);
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    chk("bready_before_rst", axi.BREADY, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID}, 3'b000);
    chk("abort_readys", {axi.BREADY, axi.RREADY}, 2'b00);
    chk("abort_bus", {bus_wait, bus_ack, bus_resp, bus_err}, 5'b0);
    chk("abort_rdata", bus_rdata, '0);
    chk("abort_capture", {axi.AWADDR, axi.WDATA}, 64'h0);
    rst = 1'b0;
    model_rdata = '0;
    repeat (4) @(negedge clk);
    chk("abort_no_ack", n_ack, start);

    run_txn('{1'b0, 32'h800, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h13579BDF, 2'b00, 1'b0, 3});

`ifdef AXI4L_MASTER_TIMEOUT_EN
    // Read whose data never arrives: timeout completion, then a late beat is drained.
    run_txn('{1'b0, 32'h500, 32'h0, 4'h0, 0, 0, -1, 2'b00, 32'h0, 2'b10, 1'b1, 2 + TO});
    chk("rready_stale", axi.RREADY, 1'b1);
    axi.RVALID = 1'b1; axi.RDATA = 32'h0000AAAA; axi.RRESP = 2'b00;
    @(negedge clk);
    axi.RVALID = 1'b0; axi.RDATA = '0;
    chk("rready_stale_clear", axi.RREADY, 1'b0);
    chk("stale_rdata_kept", bus_rdata, model_rdata);
    run_txn('{1'b0, 32'h504, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h00005555, 2'b00, 1'b0, 3});
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
